// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

  // mode = {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: half-period counter, leading/trailing strobes and sclk level.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic idle_level,
  input  logic clear,
  input  logic run,
  input  logic cpol,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb,
  output logic sclk
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV);

  logic [CNT_W-1:0] div_cnt;

  // Counter starts at 0 on clear and reloads to 1 afterwards, so the first
  // period after a start is one cycle longer than every later half-period.
  assign tick      = (div_cnt == TERM);
  assign lead_stb  = run && tick && (sclk == cpol);
  assign trail_stb = run && tick && (sclk != cpol);

  // Divider counter: cleared at transfer start, counts 1..CLK_DIV otherwise.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else if (!idle) begin
      div_cnt <= tick ? CNT_W'(1) : div_cnt + CNT_W'(1);
    end
  end

  // SCLK level: follows the idle polarity in IDLE, toggles on every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk <= 1'b0;
    end else if (idle) begin
      sclk <= idle_level;
    end else if (lead_stb || trail_stb) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one frame per start pulse, all modes.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 4,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] txdata,
  output logic [DATA_W-1:0] rxdata,
  output logic              busy,
  output logic              finish,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(2 * DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_EDGE = BIT_W'(2 * DATA_W - 1);

  spi_state_e        state, state_nxt;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [NUM_SS-1:0] sel_n;
  logic              tick, lead_stb, trail_stb;
  logic              accept, last_edge, drive_stb, sample_stb;

  assign accept     = (state == IDLE) && start;
  assign last_edge  = (bit_cnt == LAST_EDGE);
  assign drive_stb  = cpha_q ? lead_stb : (trail_stb && !last_edge);
  assign sample_stb = cpha_q ? trail_stb : lead_stb;
  assign busy       = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign finish     = (state == DONE);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .idle      (state == IDLE),
    .idle_level(mode[CPOL_BIT]),
    .clear     (accept),
    .run       (state == XFER),
    .cpol      (cpol_q),
    .tick      (tick),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sclk      (sclk)
  );

  // Slave-select decode of the requested index; out-of-range selects none.
  always_comb begin
    sel_n = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_W'(i)) sel_n[i] = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: phase lengths are paced by the divider tick.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (tick) state_nxt = XFER;
      XFER:  if (tick && last_edge) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request, shift bits on strobes, publish rxdata at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      ss_n    <= '1;
      mosi    <= 1'b0;
      rxdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          mosi <= 1'b0;
          if (start) begin
            cpol_q  <= mode[CPOL_BIT];
            cpha_q  <= mode[CPHA_BIT];
            lsb_q   <= lsb_first;
            ss_n    <= sel_n;
            rx_sr   <= '0;
            bit_cnt <= '0;
            // CPHA=0 presents the first bit before the first edge.
            if (!mode[CPHA_BIT]) begin
              mosi  <= lsb_first ? txdata[0] : txdata[DATA_W-1];
              tx_sr <= lsb_first ? (txdata >> 1) : (txdata << 1);
            end else begin
              tx_sr <= txdata;
            end
          end
        end
        XFER: begin
          if (lead_stb || trail_stb) bit_cnt <= bit_cnt + BIT_W'(1);
          if (drive_stb) begin
            mosi  <= lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
            tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
          end
          if (sample_stb) begin
            rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
          end
        end
        HOLD: begin
          if (tick) begin
            ss_n   <= '1;
            rxdata <= rx_sr;
          end
        end
        DONE: mosi <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench: two configurations (8b/div4/5 selects, 16b/div1/4 selects)
// each talking to a behavioural SPI slave.
module tb_spi_master_param;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] tx;
    logic [7:0]  ss;
    logic        first;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [1:0]       rst, start, lsb;
  logic [1:0][1:0]  mode;
  logic [1:0][2:0]  ss_sel;
  logic [1:0][15:0] txdata;

  logic [15:0] rxdata [2];
  logic [7:0]  ss_n   [2];
  logic        busy   [2];
  logic        finish [2];
  logic        sclk   [2];
  logic        mosi   [2];
  logic        miso   [2] = '{1'b0, 1'b0};

  logic [1:0]  p_mode [2];
  logic        p_lsb  [2];
  logic [15:0] p_stx  [2];
  logic [7:0]  p_ss   [2];

  exp_t sbq [2][$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DW  = (g == 0) ? 8 : 16;
    localparam int CD  = (g == 0) ? 4 : 1;
    localparam int NS  = (g == 0) ? 5 : 4;
    localparam int SW  = (g == 0) ? 3 : 2;
    localparam int LAT = (2 * DW + 2) * CD + 1;
    localparam logic [7:0] ALL1 = 8'((1 << NS) - 1);

    logic [DW-1:0] tx_l, rx_l;
    logic [SW-1:0] sel_l;
    logic [NS-1:0] ssn_l;
    logic          busy_l, fin_l, sclk_l, mosi_l;

    assign tx_l      = txdata[g][DW-1:0];
    assign sel_l     = ss_sel[g][SW-1:0];
    assign rxdata[g] = 16'(rx_l);
    assign ss_n[g]   = 8'(ssn_l);
    assign busy[g]   = busy_l;
    assign finish[g] = fin_l;
    assign sclk[g]   = sclk_l;
    assign mosi[g]   = mosi_l;

    spi_master_param #(
      .DATA_W (DW),
      .CLK_DIV(CD),
      .NUM_SS (NS)
    ) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .mode     (mode[g]),
      .lsb_first(lsb[g]),
      .ss_sel   (sel_l),
      .txdata   (tx_l),
      .rxdata   (rx_l),
      .busy     (busy_l),
      .finish   (fin_l),
      .sclk     (sclk_l),
      .ss_n     (ssn_l),
      .mosi     (mosi_l),
      .miso     (miso[g])
    );

    logic        act = 1'b0, sel = 1'b0, cpol = 1'b0, cpha = 1'b0, lsbq = 1'b0;
    logic        pbusy = 1'b0, psclk = 1'b0, lead = 1'b0, first = 1'b0;
    logic [15:0] stx = '0, srx = '0;
    logic [7:0]  ssx = '0;
    int          ntx = 0, nrx = 0, rises = 0, ss_bad = 0, pos = 0;
    exp_t        e;

    // Behavioural slave plus scoreboard monitor, evaluated away from posedge.
    always @(negedge clk) begin
      if (busy_l && !pbusy) begin
        act = 1'b1; cpol = p_mode[g][1]; cpha = p_mode[g][0]; lsbq = p_lsb[g];
        stx = p_stx[g]; ssx = p_ss[g]; sel = (ssx != ALL1);
        srx = '0; ntx = 0; nrx = 0; rises = 0; ss_bad = 0; first = 1'b0;
        miso[g] = 1'b1;
        if (sel && !cpha) begin
          miso[g] = lsbq ? stx[0] : stx[DW-1];
          ntx = 1;
        end
      end else if (act && busy_l && (sclk_l != psclk)) begin
        if (sclk_l) rises++;
        lead = (sclk_l != cpol);
        if (lead != cpha) begin
          pos = lsbq ? nrx : DW - 1 - nrx;
          if (sel && nrx < DW) srx[pos] = mosi_l;
          if (nrx == 0) first = mosi_l;
          nrx++;
        end else if (sel && ntx < DW) begin
          miso[g] = lsbq ? stx[ntx] : stx[DW-1-ntx];
          ntx++;
        end
      end
      if (busy_l && (ss_n[g] != ssx)) ss_bad++;
      if (!busy_l) act = 1'b0;
      psclk = sclk_l;
      pbusy = busy_l;

      if (fin_l) begin
        chk($sformatf("g%0d_finish_expected", g), 32'(sbq[g].size() > 0), 1);
        if (sbq[g].size() > 0) begin
          e = sbq[g].pop_front();
          chk($sformatf("g%0d_rxdata", g), rxdata[g], e.rx);
          chk($sformatf("g%0d_latency", g), cyc - e.t0, LAT);
          chk($sformatf("g%0d_sclk_rises", g), rises, DW);
          chk($sformatf("g%0d_ss_during_frame_bad", g), ss_bad, 0);
          chk($sformatf("g%0d_ss_n_done", g), ss_n[g], ALL1);
          chk($sformatf("g%0d_busy_done", g), busy_l, 0);
          if (e.ss != ALL1) begin
            chk($sformatf("g%0d_slave_rx", g), srx, e.tx);
            chk($sformatf("g%0d_first_mosi", g), first, e.first);
          end
        end
      end
    end
  end

  task automatic issue(int g, logic [1:0] m, logic l, logic [2:0] s,
                       logic [15:0] tx, logic [15:0] stx);
    int dw = (g == 0) ? 8 : 16;
    int ns = (g == 0) ? 5 : 4;
    logic [15:0] msk  = 16'((32'd1 << dw) - 1);
    logic [7:0]  all1 = 8'((1 << ns) - 1);
    exp_t e;
    e.tx    = tx & msk;
    e.ss    = (int'(s) < ns) ? (all1 & ~(8'd1 << s)) : all1;
    e.rx    = (e.ss == all1) ? msk : (stx & msk);
    e.first = l ? tx[0] : tx[dw-1];
    e.t0    = cyc + 1;
    mode[g] = m; lsb[g] = l; ss_sel[g] = s; txdata[g] = tx;
    p_mode[g] = m; p_lsb[g] = l; p_stx[g] = stx; p_ss[g] = e.ss;
    sbq[g].push_back(e);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!finish[g] && n < 400);
    chk($sformatf("g%0d_done_in_time", g), finish[g], 1);
    if (!finish[g]) sbq[g].delete();
  endtask

  initial begin
    rst = 2'b11; start = '0; lsb = '0; mode = '0; ss_sel = '0; txdata = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d_rst_ss_n", g), ss_n[g], (g == 0) ? 8'h1F : 8'h0F);
      chk($sformatf("g%0d_rst_sclk", g), sclk[g], 0);
      chk($sformatf("g%0d_rst_busy", g), busy[g], 0);
      chk($sformatf("g%0d_rst_finish", g), finish[g], 0);
      chk($sformatf("g%0d_rst_rxdata", g), rxdata[g], 0);
      chk($sformatf("g%0d_rst_mosi", g), mosi[g], 0);
    end
    rst = 2'b00;
    @(negedge clk);

    // Mode 0, MSB first, A5 out / 3C back.
    issue(0, 2'b00, 1'b0, 3'd0, 16'h00A5, 16'h003C);
    wait_done(0);
    @(negedge clk);

    // Mode 3, LSB first, idle-high sclk around the frame.
    mode[0] = 2'b11;
    @(negedge clk);
    chk("m3_sclk_idle_before", sclk[0], 1);
    issue(0, 2'b11, 1'b1, 3'd0, 16'h0001, 16'h0080);
    wait_done(0);
    chk("m3_sclk_done", sclk[0], 1);
    @(negedge clk);
    chk("m3_sclk_idle_after", sclk[0], 1);

    // 16-bit, divide-by-1, mode 1.
    issue(1, 2'b01, 1'b0, 3'd0, 16'hBEEF, 16'h1234);
    wait_done(1);
    @(negedge clk);

    // Start while busy with new inputs is ignored.
    mode[0] = 2'b00;
    issue(0, 2'b00, 1'b0, 3'd1, 16'h005A, 16'h00C3);
    repeat (9) @(negedge clk);
    txdata[0] = 16'h00FF; mode[0] = 2'b10; lsb[0] = 1'b1; ss_sel[0] = 3'd3;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    @(negedge clk);
    chk("busy_start_not_queued", busy[0], 0);

    // Reset in the middle of XFER aborts without a finish pulse.
    issue(0, 2'b00, 1'b0, 3'd0, 16'h0033, 16'h00CC);
    repeat (20) @(negedge clk);
    mode[0] = 2'b11;
    rst[0] = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    chk("abort_ss_n", ss_n[0], 8'h1F);
    chk("abort_sclk", sclk[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_rxdata", rxdata[0], 0);
    chk("abort_finish", finish[0], 0);
    rst[0] = 1'b0;
    mode[0] = 2'b00;
    repeat (100) @(negedge clk);

    // Out-of-range select, then back-to-back frame to slave 2.
    issue(0, 2'b00, 1'b0, 3'd5, 16'h0096, 16'h0069);
    wait_done(0);
    @(negedge clk);
    issue(0, 2'b00, 1'b0, 3'd2, 16'h0012, 16'h0034);
    repeat (4) @(negedge clk);
    chk("b2b_ss_n_sel2", ss_n[0], 8'h1B);
    wait_done(0);
    @(negedge clk);

    // Randomised frames on both configurations.
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 2; g++) begin
        issue(g, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, (g == 0) ? 7 : 3)),
              16'($urandom), 16'($urandom));
        wait_done(g);
        @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    chk("g0_queue_drained", sbq[0].size(), 0);
    chk("g1_queue_drained", sbq[1].size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
